cnt_seq_ctrl: RTL and testbench
===============================

CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 8, APB data width; registers use bits [7:0], upper bits read 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports psel, penable, pwrite  input  1 each  APB control.
REQ-006 SHALL have ports paddr  input  APB_ADDR_WIDTH  and pwdata  input  APB_DATA_WIDTH  APB address and write data.
REQ-007 SHALL have ports prdata  output  APB_DATA_WIDTH  read data, pready  output  1  tied 1, and pslverr  output  1  error.
REQ-008 SHALL have port cnt_en  output  1  enable to the decade counter.
REQ-009 SHALL have port cnt_clr  output  1  one-cycle synchronous clear to the counter.
REQ-010 SHALL have ports cnt_val  input  4  counter value, and cout_in  input  1  terminal-count pulse (counter at 9 and enabled).
REQ-011 SHALL have port irq  output  1  registered interrupt.

Function
REQ-012 SHALL complete an APB access when psel&penable: zero wait states; prdata and pslverr valid in that cycle, otherwise 0.
REQ-013 SHALL decode: 0x0 CTRL (b0 START W1, self-clearing; b1 STOP W1, self-clearing; b2 IRQ_EN; b3 CONT), 0x1 TERM RW, 0x2 STATUS (b1:0 state, b2 done, b3 pend; writing 1 to b3 clears pend), 0x3 WRAPS RO, 0x4 SNAP RO (b3:0).
REQ-014 SHALL assert pslverr on unmapped addresses, on writes to RO registers and on TERM writes in RUN; the erroneous write SHALL have no effect.
REQ-015 SHALL implement FSM IDLE=0, CLEAR=1, RUN=2, DONE=3.
REQ-016 SHALL go IDLE/DONE -> CLEAR on START when TERM!=0; START with TERM==0 SHALL set pslverr and leave the state unchanged.
REQ-017 SHALL, in CLEAR, drive cnt_clr=1 for exactly one cycle, clear WRAPS and done, then enter RUN.
REQ-018 SHALL drive cnt_en=1 only in RUN (combinational from state).
REQ-019 SHALL, in RUN on cout_in, increment WRAPS (8-bit); if the incremented value equals TERM, set pend, and if CONT=0 also set done and go to DONE; if CONT=1 wrap WRAPS to 0 and stay in RUN.
REQ-020 SHALL go RUN -> IDLE on STOP and capture cnt_val into SNAP in that cycle; START and STOP written together SHALL be treated as STOP only.
REQ-021 SHALL ignore START while in CLEAR or RUN, without error.
REQ-022 SHALL ignore cout_in outside RUN.
REQ-023 SHALL give set priority over clear when the hardware setting pend and the W1C clearing pend fall in the same cycle (pend stays 1).
REQ-024 SHALL register irq = pend & IRQ_EN, one cycle after either changes.

Reset
REQ-025 SHALL, on rstn=0 at posedge clk, set state IDLE and clear all registers, cnt_en, cnt_clr, irq, prdata and pslverr to 0, including mid-RUN.
REQ-026 SHALL ignore APB accesses while rstn=0.

Configuration
REQ-027 SHALL, with macro CNT_SEQ_SNAP_EN defined, implement SNAP as specified.
REQ-028 SHALL, without CNT_SEQ_SNAP_EN, omit the SNAP storage and treat 0x4 as unmapped (pslverr=1, prdata=0); STOP behaviour is otherwise unchanged.

Verification
REQ-029 SHALL cover: TERM=3, START -> cnt_clr high for 1 cycle, cnt_en high; after the 3rd cout_in, state=DONE, done=1, WRAPS=3, cnt_en=0 the next cycle.
REQ-030 SHALL cover: IRQ_EN=1, CONT=1, TERM=2, 4 cout_in pulses -> pend set at pulses 2 and 4, irq high one cycle after; W1C on pend clears irq; state stays RUN.
REQ-031 SHALL cover: in RUN with cnt_val=7, STOP -> IDLE, SNAP=7 (macro on), or a 0x4 read gives pslverr=1, prdata=0 (macro off).
REQ-032 SHALL cover: TERM=0 then START -> pslverr=1, state=IDLE; TERM write in RUN -> pslverr=1, TERM unchanged.
REQ-033 SHALL cover: W1C on pend in the same cycle as a terminal cout_in -> pend=1.
REQ-034 SHALL cover: rstn=0 mid-RUN with WRAPS=5 -> next cycle state=IDLE, WRAPS=0, cnt_en=0, irq=0.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// APB-controlled sequencer for an external decade counter: counts terminal-count wraps up to TERM.
// Optional SNAP register (counter value captured on STOP) is built only when CNT_SEQ_SNAP_EN is defined.
module cnt_seq_ctrl #(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int APB_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      cnt_en,
  output logic                      cnt_clr,
  input  logic [3:0]                cnt_val,
  input  logic                      cout_in,
  output logic                      irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'(0);
  localparam logic [APB_ADDR_WIDTH-1:0] A_TERM   = APB_ADDR_WIDTH'(1);
  localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(2);
  localparam logic [APB_ADDR_WIDTH-1:0] A_WRAPS  = APB_ADDR_WIDTH'(3);
`ifdef CNT_SEQ_SNAP_EN
  localparam logic [APB_ADDR_WIDTH-1:0] A_SNAP   = APB_ADDR_WIDTH'(4);
`endif

  state_t     state;
  logic       irq_en;
  logic       cont;
  logic       done;
  logic       pend;
  logic [7:0] term;
  logic [7:0] wraps;
`ifdef CNT_SEQ_SNAP_EN
  logic [3:0] snap;
`else
  logic       cnt_val_unused;
  assign cnt_val_unused = ^cnt_val;
`endif

  logic       access;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       err;
  logic       ctrl_wr;
  logic       term_wr;
  logic       pend_w1c;
  logic       start_req;
  logic       stop_req;
  logic [7:0] wraps_inc;
  logic       term_hit;

  // Register decode; an access is only honoured out of reset, and an erroneous write changes nothing.
  always_comb begin
    access    = rstn & psel & penable;
    wdata     = pwdata[7:0];
    rdata     = 8'd0;
    err       = 1'b0;
    ctrl_wr   = 1'b0;
    term_wr   = 1'b0;
    pend_w1c  = 1'b0;
    start_req = 1'b0;
    stop_req  = 1'b0;
    if (access) begin
      case (paddr)
        A_CTRL: begin
          rdata = {4'd0, cont, irq_en, 2'd0};
          if (pwrite) begin
            if (wdata[0] && !wdata[1] && (state == S_IDLE || state == S_DONE) && term == 8'd0) begin
              err = 1'b1;
            end else begin
              ctrl_wr   = 1'b1;
              start_req = wdata[0] & ~wdata[1];
              stop_req  = wdata[1];
            end
          end
        end
        A_TERM: begin
          rdata = term;
          if (pwrite) begin
            if (state == S_RUN) err = 1'b1;
            else term_wr = 1'b1;
          end
        end
        A_STATUS: begin
          rdata = {4'd0, pend, done, state};
          if (pwrite) pend_w1c = wdata[3];
        end
        A_WRAPS: begin
          rdata = wraps;
          if (pwrite) err = 1'b1;
        end
`ifdef CNT_SEQ_SNAP_EN
        A_SNAP: begin
          rdata = {4'd0, snap};
          if (pwrite) err = 1'b1;
        end
`endif
        default: err = 1'b1;
      endcase
    end
  end

  // STOP outranks a coincident terminal count.
  always_comb begin
    wraps_inc = wraps + 8'd1;
    term_hit  = (state == S_RUN) && cout_in && !stop_req && (wraps_inc == term);
  end

  always_comb begin
    prdata      = '0;
    prdata[7:0] = rdata;
  end

  assign pslverr = err;
  assign pready  = 1'b1;
  assign cnt_en  = (state == S_RUN);
  assign cnt_clr = (state == S_CLEAR);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      irq_en <= 1'b0;
      cont   <= 1'b0;
      done   <= 1'b0;
      pend   <= 1'b0;
      term   <= 8'd0;
      wraps  <= 8'd0;
      irq    <= 1'b0;
`ifdef CNT_SEQ_SNAP_EN
      snap   <= 4'd0;
`endif
    end else begin
      irq <= pend & irq_en;
      if (ctrl_wr) begin
        irq_en <= wdata[2];
        cont   <= wdata[3];
      end
      if (term_wr) term <= wdata;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_req) state <= S_CLEAR;
        end
        S_CLEAR: begin
          wraps <= 8'd0;
          done  <= 1'b0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (stop_req) begin
            state <= S_IDLE;
`ifdef CNT_SEQ_SNAP_EN
            snap  <= cnt_val;
`endif
          end else if (cout_in) begin
            if (term_hit && cont) begin
              wraps <= 8'd0;
            end else if (term_hit) begin
              wraps <= wraps_inc;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              wraps <= wraps_inc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // A hardware set wins over a same-cycle write-one-to-clear.
      if (term_hit) pend <= 1'b1;
      else if (pend_w1c) pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: APB register access, run/stop/continuous sequencing, irq, reset.
// Handles both builds of the SNAP register (CNT_SEQ_SNAP_EN defined or not).
`timescale 1ns/1ps
module tb_cnt_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] cnt_val;
  logic       cout_in;
  logic       irq;

  int total = 0;
  int bad   = 0;

  cnt_seq_ctrl #(.APB_ADDR_WIDTH(8), .APB_DATA_WIDTH(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr),
    .cnt_val (cnt_val),
    .cout_in (cout_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic apb(input logic w, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    @(posedge clk);
    #1 penable = 1'b1;
    @(negedge clk);
    rd = prdata;
    er = pslverr;
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [7:0] d, input logic exp_err);
    logic [7:0] rd;
    logic       er;
    apb(1'b1, a, d, rd, er);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp_data, input logic exp_err);
    logic [7:0] rd;
    logic       er;
    apb(1'b0, a, 8'h00, rd, er);
    chk({tag, "_data"}, 32'(rd), 32'(exp_data));
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic pulse_cout();
    cout_in = 1'b1;
    @(posedge clk);
    #1 cout_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; cnt_val = 4'd0; cout_in = 1'b0;

    // Reset state, and an APB write attempted under reset must be ignored.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_cnt_clr", 32'(cnt_clr), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_pready", 32'(pready), 1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h05;
    @(negedge clk);
    chk("rst_prdata", 32'(prdata), 0);
    chk("rst_pslverr", 32'(pslverr), 0);
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rstn = 1'b1;
    rd_chk("rst_term", 8'h01, 8'h00, 1'b0);
    rd_chk("rst_ctrl", 8'h00, 8'h00, 1'b0);
    rd_chk("rst_status", 8'h02, 8'h00, 1'b0);
    rd_chk("rst_wraps", 8'h03, 8'h00, 1'b0);

    // START with TERM==0 errors and stays IDLE; unmapped and RO accesses error.
    wr_chk("start_term0", 8'h00, 8'h01, 1'b1);
    chk("start_term0_clr", 32'(cnt_clr), 0);
    rd_chk("start_term0_status", 8'h02, 8'h00, 1'b0);
    rd_chk("unmapped", 8'h07, 8'h00, 1'b1);
    wr_chk("wraps_ro", 8'h03, 8'h44, 1'b1);
    rd_chk("wraps_after_ro", 8'h03, 8'h00, 1'b0);
`ifdef CNT_SEQ_SNAP_EN
    rd_chk("snap_rst", 8'h04, 8'h00, 1'b0);
    wr_chk("snap_ro", 8'h04, 8'h03, 1'b1);
`else
    rd_chk("snap_unmapped", 8'h04, 8'h00, 1'b1);
`endif

    // Single-shot run to TERM=3.
    wr_chk("term3", 8'h01, 8'h03, 1'b0);
    wr_chk("start1", 8'h00, 8'h01, 1'b0);
    chk("clear_cnt_clr", 32'(cnt_clr), 1);
    chk("clear_cnt_en", 32'(cnt_en), 0);
    tick();
    chk("run_cnt_clr", 32'(cnt_clr), 0);
    chk("run_cnt_en", 32'(cnt_en), 1);
    wr_chk("term_in_run", 8'h01, 8'h09, 1'b1);
    rd_chk("term_kept", 8'h01, 8'h03, 1'b0);
    wr_chk("start_in_run", 8'h00, 8'h01, 1'b0);
    chk("start_in_run_en", 32'(cnt_en), 1);
    pulse_cout();
    pulse_cout();
    rd_chk("wraps2", 8'h03, 8'h02, 1'b0);
    rd_chk("status_run", 8'h02, 8'h02, 1'b0);
    pulse_cout();
    chk("done_cnt_en", 32'(cnt_en), 0);
    rd_chk("status_done", 8'h02, 8'h0F, 1'b0);
    rd_chk("wraps3", 8'h03, 8'h03, 1'b0);
    chk("done_irq_off", 32'(irq), 0);
    pulse_cout();
    rd_chk("wraps_ign_done", 8'h03, 8'h03, 1'b0);
    wr_chk("w1c_done", 8'h02, 8'h08, 1'b0);
    rd_chk("status_w1c", 8'h02, 8'h07, 1'b0);

    // Continuous mode, TERM=2, irq enabled.
    wr_chk("term2", 8'h01, 8'h02, 1'b0);
    wr_chk("start_cont", 8'h00, 8'h0D, 1'b0);
    chk("cont_clr", 32'(cnt_clr), 1);
    tick();
    chk("cont_en", 32'(cnt_en), 1);
    rd_chk("cont_status0", 8'h02, 8'h02, 1'b0);
    rd_chk("ctrl_rb", 8'h00, 8'h0C, 1'b0);
    pulse_cout();
    chk("p1_irq", 32'(irq), 0);
    pulse_cout();
    chk("p2_irq_lag", 32'(irq), 0);
    tick();
    chk("p2_irq", 32'(irq), 1);
    rd_chk("p2_status", 8'h02, 8'h0A, 1'b0);
    wr_chk("p2_w1c", 8'h02, 8'h08, 1'b0);
    chk("w1c_irq_lag", 32'(irq), 1);
    tick();
    chk("w1c_irq", 32'(irq), 0);
    pulse_cout();
    rd_chk("p3_wraps", 8'h03, 8'h01, 1'b0);
    chk("p3_irq", 32'(irq), 0);
    pulse_cout();
    tick();
    chk("p4_irq", 32'(irq), 1);
    rd_chk("p4_status", 8'h02, 8'h0A, 1'b0);
    rd_chk("p4_wraps", 8'h03, 8'h00, 1'b0);

    // W1C coinciding with the terminal cout_in: pend must stay set.
    wr_chk("pre_w1c", 8'h02, 8'h08, 1'b0);
    rd_chk("pre_w1c_status", 8'h02, 8'h02, 1'b0);
    pulse_cout();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h08;
    @(posedge clk);
    #1;
    penable = 1'b1;
    cout_in = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; cout_in = 1'b0;
    rd_chk("race_status", 8'h02, 8'h0A, 1'b0);
    rd_chk("race_wraps", 8'h03, 8'h00, 1'b0);

    // START+STOP together acts as STOP; snapshot of cnt_val.
    cnt_val = 4'd7;
    wr_chk("stop", 8'h00, 8'h07, 1'b0);
    chk("stop_cnt_en", 32'(cnt_en), 0);
    chk("stop_cnt_clr", 32'(cnt_clr), 0);
    cnt_val = 4'd2;
    rd_chk("stop_status", 8'h02, 8'h08, 1'b0);
`ifdef CNT_SEQ_SNAP_EN
    rd_chk("snap7", 8'h04, 8'h07, 1'b0);
`else
    rd_chk("snap_off", 8'h04, 8'h00, 1'b1);
`endif

    // Reset in the middle of a run with WRAPS=5 and irq asserted.
    wr_chk("term9", 8'h01, 8'h09, 1'b0);
    wr_chk("start_rst", 8'h00, 8'h05, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) pulse_cout();
    rd_chk("wraps5", 8'h03, 8'h05, 1'b0);
    chk("pre_rst_irq", 32'(irq), 1);
    chk("pre_rst_en", 32'(cnt_en), 1);
    rstn = 1'b0;
    tick();
    chk("midrst_cnt_en", 32'(cnt_en), 0);
    chk("midrst_irq", 32'(irq), 0);
    chk("midrst_cnt_clr", 32'(cnt_clr), 0);
    rstn = 1'b1;
    rd_chk("midrst_wraps", 8'h03, 8'h00, 1'b0);
    rd_chk("midrst_status", 8'h02, 8'h00, 1'b0);
    rd_chk("midrst_term", 8'h01, 8'h00, 1'b0);
    rd_chk("midrst_ctrl", 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
